// File: rtl/wb_forwarder.sv
// Writeback / forwarding producer.
// Merges load results (always accepted, highest priority) with execute results
// (buffered in a small FIFO) into one registered write port per cycle. The
// registered strobes, key and value double as the forwarding bus.
module wb_forwarder #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_writes,
  input  logic          ex_is_float,
  input  logic [4:0]    ex_rd,
  input  logic [31:0]   ex_value,
  input  logic          mem_valid,
  input  logic          mem_is_float,
  input  logic [4:0]    mem_rd,
  input  logic [31:0]   mem_value,
  output logic          reg_we,
  output logic          freg_we,
  output logic [4:0]    wb_key,
  output logic [31:0]   wb_value,
  output logic [CW-1:0] pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        is_float;
    logic [4:0]  rd;
    logic [31:0] value;
  } entry_t;

  entry_t        fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic          fifo_empty;
  logic          push, store, pop, bypass;
  logic          sel_valid;
  entry_t        ex_entry, mem_entry, head_entry, sel_entry;

  logic          reg_we_reg, reg_we_next;
  logic          freg_we_reg, freg_we_next;
  logic [4:0]    key_reg, key_next;
  logic [31:0]   value_reg, value_next;

  assign ex_entry   = '{is_float: ex_is_float,  rd: ex_rd,  value: ex_value};
  assign mem_entry  = '{is_float: mem_is_float, rd: mem_rd, value: mem_value};
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign fifo_empty = (count_reg == '0);

  // Readiness depends on occupancy only, so a pop in the same cycle never
  // opens a slot for the incoming entry.
  assign ex_ready = (count_reg < CW'(DEPTH));

  // Arbitration: load first, then oldest queued entry, then bypass of a
  // fresh entry into an empty FIFO; non-writing entries are simply dropped.
  always_comb begin
    push         = ex_valid && ex_ready;
    pop          = !mem_valid && !fifo_empty;
    bypass       = !mem_valid && fifo_empty && push && ex_writes;
    store        = push && ex_writes && !bypass;
    sel_valid    = 1'b0;
    sel_entry    = ex_entry;
    if (mem_valid) begin
      sel_valid = 1'b1;
      sel_entry = mem_entry;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_entry = head_entry;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_entry = ex_entry;
    end
    count_next   = count_reg + CW'(store) - CW'(pop);
    wr_ptr_next  = store ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next  = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    // x0 is hard-wired zero: its slot is consumed but no integer write issues.
    reg_we_next  = sel_valid && !sel_entry.is_float && (sel_entry.rd != 5'd0);
    freg_we_next = sel_valid && sel_entry.is_float;
    key_next     = sel_valid ? sel_entry.rd : key_reg;
    value_next   = sel_valid ? sel_entry.value : value_reg;
  end

  // FIFO storage; contents need no reset because pointers and count do.
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_mem[wr_ptr_reg] <= ex_entry;
    end
  end

  // Pointer, occupancy and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      reg_we_reg  <= 1'b0;
      freg_we_reg <= 1'b0;
      key_reg     <= '0;
      value_reg   <= '0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      reg_we_reg  <= reg_we_next;
      freg_we_reg <= freg_we_next;
      key_reg     <= key_next;
      value_reg   <= value_next;
    end
  end

  assign reg_we   = reg_we_reg;
  assign freg_we  = freg_we_reg;
  assign wb_key   = key_reg;
  assign wb_value = value_reg;
  assign pending  = count_reg;

endmodule

// File: tb/tb_wb_forwarder.sv
// Self-checking bench for wb_forwarder (DEPTH=2).
// Each vector holds one cycle of stimulus plus the hand-derived result seen
// after the following clock edge; expected writes go through a scoreboard.
module tb_wb_forwarder;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rstn;
  logic          ex_valid, ex_ready, ex_writes, ex_is_float;
  logic [4:0]    ex_rd;
  logic [31:0]   ex_value;
  logic          mem_valid, mem_is_float;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_value;
  logic          reg_we, freg_we;
  logic [4:0]    wb_key;
  logic [31:0]   wb_value;
  logic [CW-1:0] pending;

  wb_forwarder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_writes(ex_writes),
    .ex_is_float(ex_is_float), .ex_rd(ex_rd), .ex_value(ex_value),
    .mem_valid(mem_valid), .mem_is_float(mem_is_float), .mem_rd(mem_rd),
    .mem_value(mem_value),
    .reg_we(reg_we), .freg_we(freg_we), .wb_key(wb_key), .wb_value(wb_value),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv, mf;
    logic [4:0]  mrd;
    logic [31:0] mval;
    logic        ev, ew, ef;
    logic [4:0]  erd;
    logic [31:0] evl;
    logic        rdy, rwe, fwe;
    logic [CW-1:0] pend;
    logic        xv, xf;
    logic [4:0]  xk;
    logic [31:0] xval;
  } vec_t;

  typedef struct {
    logic        f;
    logic [4:0]  k;
    logic [31:0] v;
  } wr_t;

  wr_t sb[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  function automatic vec_t V(input int mv, mf, mrd, mval, ev, ew, ef, erd, evl,
                             input int rdy, rwe, fwe, pend, xv, xf, xk, xval);
    vec_t v;
    v.mv = 1'(mv);   v.mf = 1'(mf);   v.mrd = 5'(mrd);  v.mval = mval;
    v.ev = 1'(ev);   v.ew = 1'(ew);   v.ef = 1'(ef);    v.erd = 5'(erd);
    v.evl = evl;     v.rdy = 1'(rdy); v.rwe = 1'(rwe);  v.fwe = 1'(fwe);
    v.pend = CW'(pend);
    v.xv = 1'(xv);   v.xf = 1'(xf);   v.xk = 5'(xk);    v.xval = xval;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_valid = 1'b0; mem_is_float = 1'b0; mem_rd = '0; mem_value = '0;
    ex_valid = 1'b0; ex_writes = 1'b0; ex_is_float = 1'b0; ex_rd = '0; ex_value = '0;
  endtask

  // One cycle: drive, check ready, push expected write, clock, check outputs
  // and pop the scoreboard when a strobe shows up.
  task automatic apply(input int idx, input vec_t v);
    wr_t e;
    mem_valid = v.mv; mem_is_float = v.mf; mem_rd = v.mrd; mem_value = v.mval;
    ex_valid = v.ev; ex_writes = v.ew; ex_is_float = v.ef; ex_rd = v.erd; ex_value = v.evl;
    #1;
    chk($sformatf("v%0d ex_ready", idx), 32'(ex_ready), 32'(v.rdy));
    if (v.xv) sb.push_back('{f: v.xf, k: v.xk, v: v.xval});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d reg_we", idx), 32'(reg_we), 32'(v.rwe));
    chk($sformatf("v%0d freg_we", idx), 32'(freg_we), 32'(v.fwe));
    chk($sformatf("v%0d pending", idx), 32'(pending), 32'(v.pend));
    if (reg_we || freg_we) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL v%0d unexpected_write: got key %0d value %h expected none", idx, wb_key, wb_value);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d sb_float", idx), 32'(freg_we), 32'(e.f));
        chk($sformatf("v%0d sb_key", idx), 32'(wb_key), 32'(e.k));
        chk($sformatf("v%0d sb_value", idx), wb_value, e.v);
      end
    end
    $display("vec %0d: rdy=%b we=%b fwe=%b key=%0d val=%h pend=%0d",
             idx, v.rdy, reg_we, freg_we, wb_key, wb_value, pending);
  endtask

  vec_t vecs[22];
  vec_t rv[2];
  vec_t idle_v;

  initial begin
    //           mv mf mrd mval          ev ew ef erd evl           rdy rwe fwe pnd xv xf xk xval
    vecs[0]  = V(0, 0, 0,  0,            1, 1, 0, 5,  32'h2A,       1,  1,  0,  0,  1, 0, 5,  32'h2A);
    vecs[1]  = V(0, 0, 0,  0,            0, 0, 0, 0,  0,            1,  0,  0,  0,  0, 0, 0,  0);
    vecs[2]  = V(1, 1, 3,  32'h3F800000, 1, 1, 0, 7,  32'h11,       1,  0,  1,  1,  1, 1, 3,  32'h3F800000);
    vecs[3]  = V(0, 0, 0,  0,            0, 0, 0, 0,  0,            1,  1,  0,  0,  1, 0, 7,  32'h11);
    vecs[4]  = V(0, 0, 0,  0,            0, 0, 0, 0,  0,            1,  0,  0,  0,  0, 0, 0,  0);
    vecs[5]  = V(1, 0, 20, 32'h100,      1, 1, 0, 10, 1,            1,  1,  0,  1,  1, 0, 20, 32'h100);
    vecs[6]  = V(1, 0, 21, 32'h101,      1, 1, 0, 11, 2,            1,  1,  0,  2,  1, 0, 21, 32'h101);
    vecs[7]  = V(1, 0, 22, 32'h102,      1, 1, 0, 12, 3,            0,  1,  0,  2,  1, 0, 22, 32'h102);
    vecs[8]  = V(1, 0, 23, 32'h103,      1, 1, 0, 12, 3,            0,  1,  0,  2,  1, 0, 23, 32'h103);
    vecs[9]  = V(0, 0, 0,  0,            1, 1, 0, 12, 3,            0,  1,  0,  1,  1, 0, 10, 1);
    vecs[10] = V(0, 0, 0,  0,            1, 1, 0, 12, 3,            1,  1,  0,  1,  1, 0, 11, 2);
    vecs[11] = V(0, 0, 0,  0,            0, 0, 0, 0,  0,            1,  1,  0,  0,  1, 0, 12, 3);
    vecs[12] = V(0, 0, 0,  0,            0, 0, 0, 0,  0,            1,  0,  0,  0,  0, 0, 0,  0);
    vecs[13] = V(0, 0, 0,  0,            1, 1, 0, 0,  32'hFFFFFFFF, 1,  0,  0,  0,  0, 0, 0,  0);
    vecs[14] = V(0, 0, 0,  0,            1, 1, 1, 0,  5,            1,  0,  1,  0,  1, 1, 0,  5);
    vecs[15] = V(1, 0, 1,  32'hA,        1, 1, 0, 13, 32'h13,       1,  1,  0,  1,  1, 0, 1,  32'hA);
    vecs[16] = V(1, 0, 2,  32'hB,        1, 1, 0, 14, 32'h14,       1,  1,  0,  2,  1, 0, 2,  32'hB);
    vecs[17] = V(1, 1, 3,  32'hC,        1, 0, 0, 15, 32'h99,       0,  0,  1,  2,  1, 1, 3,  32'hC);
    vecs[18] = V(0, 0, 0,  0,            1, 0, 0, 15, 32'h99,       0,  1,  0,  1,  1, 0, 13, 32'h13);
    vecs[19] = V(0, 0, 0,  0,            1, 0, 0, 15, 32'h99,       1,  1,  0,  0,  1, 0, 14, 32'h14);
    vecs[20] = V(0, 0, 0,  0,            1, 0, 0, 15, 32'h99,       1,  0,  0,  0,  0, 0, 0,  0);
    vecs[21] = V(0, 0, 0,  0,            0, 0, 0, 0,  0,            1,  0,  0,  0,  0, 0, 0,  0);
    rv[0]    = V(1, 0, 4,  32'h40,       1, 1, 0, 16, 32'h16,       1,  1,  0,  1,  1, 0, 4,  32'h40);
    rv[1]    = V(1, 0, 5,  32'h50,       1, 1, 0, 17, 32'h17,       1,  1,  0,  2,  1, 0, 5,  32'h50);
    idle_v   = vecs[21];

    // Reset state
    rstn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst reg_we", 32'(reg_we), 32'd0);
    chk("rst freg_we", 32'(freg_we), 32'd0);
    chk("rst wb_key", 32'(wb_key), 32'd0);
    chk("rst wb_value", wb_value, 32'd0);
    chk("rst pending", 32'(pending), 32'd0);
    chk("rst ex_ready", 32'(ex_ready), 32'd1);
    #3 rstn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 22; i++) apply(i, vecs[i]);

    // Key and value hold the last write across idle cycles.
    chk("hold wb_key", 32'(wb_key), 32'd14);
    chk("hold wb_value", wb_value, 32'h14);

    // Reset mid-transfer: two entries queued, integer write on the bus.
    apply(100, rv[0]);
    apply(101, rv[1]);
    drive_idle();
    rstn = 1'b0;
    #1;
    chk("midrst reg_we", 32'(reg_we), 32'd0);
    chk("midrst freg_we", 32'(freg_we), 32'd0);
    chk("midrst wb_key", 32'(wb_key), 32'd0);
    chk("midrst wb_value", wb_value, 32'd0);
    chk("midrst pending", 32'(pending), 32'd0);
    chk("midrst ex_ready", 32'(ex_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    for (int i = 0; i < 4; i++) apply(200 + i, idle_v);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
